// File: rtl/mem_readback_streamer.sv
// Sweeps a registered-read block RAM from address 0 to DEPTH_MEM-1 and replays each word
// as an address-tagged valid/ready beat, keeping a 16-bit additive checksum of accepted data.
module mem_readback_streamer #(
    parameter int ADDR_W    = 14,
    parameter int WID_MEM   = 2,
    parameter int DEPTH_MEM = 16384
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  raddr,
    input  logic [WID_MEM-1:0] rdata,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WID_MEM-1:0] m_data,
    output logic [ADDR_W-1:0]  m_addr,
    output logic               m_last,
    output logic               busy,
    output logic               done,
    output logic [15:0]        checksum
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH_MEM - 1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    state_t state, state_nxt;

    logic [ADDR_W:0]    cnt_p0;
    logic [ADDR_W-1:0]  raddr_q;
    logic               issue_p0;
    logic [1:0]         credit_p0;

    logic               vld_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic               last_p1;

    logic [WID_MEM-1:0] fifo_data [2];
    logic [ADDR_W-1:0]  fifo_addr [2];
    logic               fifo_last [2];
    logic               rd_ptr, wr_ptr;
    logic [1:0]         fifo_count;
    logic               push, pop;

    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [WID_MEM-1:0] d);
        return acc + 16'(d);
    endfunction

    // A slot freed by this cycle's pop can be reused, which keeps one beat per cycle
    // while the FIFO plus the read in flight never exceed two entries.
    assign push      = vld_p1;
    assign pop       = m_valid & m_ready;
    assign credit_p0 = fifo_count - 2'(pop) + 2'(vld_p1);
    assign issue_p0  = (state == READ) && (credit_p0 < 2'd2);
    assign raddr     = issue_p0 ? cnt_p0[ADDR_W-1:0] : raddr_q;

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_addr  = m_valid ? fifo_addr[rd_ptr] : '0;
    assign m_last  = m_valid & fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = READ;
            READ: begin
                busy = 1'b1;
                if (issue_p0 && cnt_p0 == LAST_ADDR) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && m_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: issue counter, held read address, in-flight flag, FIFO control, checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p0     <= '0;
            raddr_q    <= '0;
            vld_p1     <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            checksum   <= 16'd0;
        end else begin
            raddr_q <= raddr;
            vld_p1  <= issue_p0;
            if (state == IDLE && start) begin
                cnt_p0   <= '0;
                checksum <= 16'd0;
            end else begin
                if (issue_p0) cnt_p0 <= cnt_p0 + CNT_ONE;
                if (pop)      checksum <= csum_add(checksum, m_data);
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

    // p1 -> FIFO: tag the read in flight, then capture the RAM word one cycle later
    always_ff @(posedge clk) begin
        if (issue_p0) begin
            addr_p1 <= cnt_p0[ADDR_W-1:0];
            last_p1 <= (cnt_p0 == LAST_ADDR);
        end
        if (push) begin
            fifo_data[wr_ptr] <= rdata;
            fifo_addr[wr_ptr] <= addr_p1;
            fifo_last[wr_ptr] <= last_p1;
        end
    end

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Bench for mem_readback_streamer: a full-size instance swept under several ready patterns,
// and a two-word instance stepped cycle by cycle through a vector table.
module tb_mem_readback_streamer;

    localparam int AW    = 14;
    localparam int DW    = 2;
    localparam int DEPTH = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic          start_a, m_ready_a, m_valid_a, m_last_a, busy_a, done_a;
    logic [AW-1:0] raddr_a, m_addr_a;
    logic [DW-1:0] rdata_a, m_data_a;
    logic [15:0]   checksum_a;
    logic [DW-1:0] mem_a [DEPTH];

    logic          start_b, m_ready_b, m_valid_b, m_last_b, busy_b, done_b;
    logic [0:0]    raddr_b, m_addr_b;
    logic [DW-1:0] rdata_b, m_data_b;
    logic [15:0]   checksum_b;
    logic [DW-1:0] mem_b [2];

    always @(posedge clk) rdata_a <= mem_a[raddr_a];
    always @(posedge clk) rdata_b <= mem_b[raddr_b];

    mem_readback_streamer #(.ADDR_W(AW), .WID_MEM(DW), .DEPTH_MEM(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .raddr(raddr_a), .rdata(rdata_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_addr(m_addr_a),
        .m_last(m_last_a), .busy(busy_a), .done(done_a), .checksum(checksum_a)
    );

    mem_readback_streamer #(.ADDR_W(1), .WID_MEM(DW), .DEPTH_MEM(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .raddr(raddr_b), .rdata(rdata_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_addr(m_addr_b),
        .m_last(m_last_b), .busy(busy_b), .done(done_b), .checksum(checksum_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start;
        logic        ready;
        logic        vld;
        logic [1:0]  data;
        logic        addr;
        logic        last;
        logic        busy;
        logic        done;
        logic [15:0] cs;
    } vec_t;

    vec_t tab [17];

    function automatic vec_t mk(input logic s, input logic r, input logic v, input logic [1:0] d,
                                input logic a, input logic l, input logic b, input logic dn,
                                input logic [15:0] c);
        vec_t t;
        t.start = s; t.ready = r; t.vld = v; t.data = d; t.addr = a;
        t.last = l; t.busy = b; t.done = dn; t.cs = c;
        return t;
    endfunction

    // mode 0: ready always 1; mode 1: ready 1,0,1,0...; mode 2: ready 0 for 20 cycles,
    // plus stray start pulses at cycle 5 and at the done cycle
    task automatic sweep_a(input string tag, input int mode, input int exp_cs, input int exp_done);
        int            exp_addr = 0;
        int            nbeats   = 0;
        int            errs     = 0;
        int            ndone    = 0;
        int            done_k   = 0;
        int            max_raddr = 0;
        logic          stall_prev = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [AW-1:0] pa = '0;
        logic          rdy;
        @(negedge clk);
        start_a   = 1'b1;
        m_ready_a = 1'b1;
        for (int k = 1; k <= 4 * DEPTH && !(done_k > 0 && k > done_k + 3); k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (mode == 2 && k == 5) start_a = 1'b1;
            if (mode == 2 && done_a) start_a = 1'b1;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? k[0] : (k > 20);
            m_ready_a = rdy;
            if (mode == 2 && k <= 20 && int'(raddr_a) > max_raddr) max_raddr = int'(raddr_a);
            if (mode == 2 && k == 20) begin
                check({tag, " stalled m_valid"}, m_valid_a, 1);
                check({tag, " stalled m_addr"}, m_addr_a, 0);
            end
            if (stall_prev && (!m_valid_a || m_data_a != pd || m_addr_a != pa)) errs++;
            if (m_valid_a && rdy) begin
                if (int'(m_addr_a) != exp_addr || m_data_a != mem_a[exp_addr[AW-1:0]] ||
                    m_last_a != (exp_addr == DEPTH - 1)) errs++;
                exp_addr++;
                nbeats++;
            end
            stall_prev = m_valid_a && !rdy;
            pd = m_data_a;
            pa = m_addr_a;
            if (done_k > 0 && busy_a) errs++;
            if (done_a) begin
                ndone++;
                if (done_k == 0) done_k = k;
            end
        end
        start_a = 1'b0;
        check({tag, " done seen"}, (done_k > 0) ? 1 : 0, 1);
        check({tag, " beat count"}, nbeats, DEPTH);
        check({tag, " beat order/data/stability errors"}, errs, 0);
        check({tag, " done pulses"}, ndone, 1);
        check({tag, " checksum"}, checksum_a, exp_cs);
        if (exp_done > 0) check({tag, " done latency"}, done_k, exp_done);
        if (mode == 2) check({tag, " highest raddr while stalled"}, max_raddr, 1);
    endtask

    initial begin
        reset = 1'b0;
        start_a = 1'b0; m_ready_a = 1'b0;
        start_b = 1'b0; m_ready_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_a[i] = 2'b11;
        mem_b[0] = 2'b10;
        mem_b[1] = 2'b01;

        //        start ready vld data addr last busy done cs
        tab[0]  = mk(1, 1, 0, 2'd0, 0, 0, 0, 0, 16'd0);
        tab[1]  = mk(0, 1, 0, 2'd0, 0, 0, 1, 0, 16'd0);
        tab[2]  = mk(0, 1, 0, 2'd0, 0, 0, 1, 0, 16'd0);
        tab[3]  = mk(0, 1, 1, 2'd2, 0, 0, 1, 0, 16'd0);
        tab[4]  = mk(0, 1, 1, 2'd1, 1, 1, 1, 0, 16'd2);
        tab[5]  = mk(0, 1, 0, 2'd0, 0, 0, 0, 1, 16'd3);
        tab[6]  = mk(1, 0, 0, 2'd0, 0, 0, 0, 0, 16'd3);
        tab[7]  = mk(0, 0, 0, 2'd0, 0, 0, 1, 0, 16'd0);
        tab[8]  = mk(0, 0, 0, 2'd0, 0, 0, 1, 0, 16'd0);
        tab[9]  = mk(0, 0, 1, 2'd2, 0, 0, 1, 0, 16'd0);
        tab[10] = mk(0, 0, 1, 2'd2, 0, 0, 1, 0, 16'd0);
        tab[11] = mk(0, 1, 1, 2'd2, 0, 0, 1, 0, 16'd0);
        tab[12] = mk(0, 0, 1, 2'd1, 1, 1, 1, 0, 16'd2);
        tab[13] = mk(0, 1, 1, 2'd1, 1, 1, 1, 0, 16'd2);
        tab[14] = mk(1, 1, 0, 2'd0, 0, 0, 0, 1, 16'd3);
        tab[15] = mk(0, 1, 0, 2'd0, 0, 0, 0, 0, 16'd3);
        tab[16] = mk(0, 1, 0, 2'd0, 0, 0, 0, 0, 16'd3);

        repeat (3) @(negedge clk);
        check("reset m_valid", m_valid_a, 0);
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset checksum", checksum_a, 0);
        check("reset raddr", raddr_a, 0);
        reset = 1'b1;

        // T6: two-word instance, full throughput then backpressure, start during DONE
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check($sformatf("T6 row%0d m_valid", i), m_valid_b, tab[i].vld);
            check($sformatf("T6 row%0d busy", i), busy_b, tab[i].busy);
            check($sformatf("T6 row%0d done", i), done_b, tab[i].done);
            check($sformatf("T6 row%0d checksum", i), checksum_b, tab[i].cs);
            if (tab[i].vld) begin
                check($sformatf("T6 row%0d m_data", i), m_data_b, tab[i].data);
                check($sformatf("T6 row%0d m_addr", i), m_addr_b, tab[i].addr);
                check($sformatf("T6 row%0d m_last", i), m_last_b, tab[i].last);
            end
            start_b   = tab[i].start;
            m_ready_b = tab[i].ready;
        end
        start_b = 1'b0;

        sweep_a("T1", 0, 16'hC000, DEPTH + 3);
        for (int i = 0; i < DEPTH; i++) mem_a[i] = 2'(i);
        sweep_a("T2", 1, 16'h6000, -1);
        sweep_a("T3T4", 2, 16'h6000, -1);

        // T5: asynchronous abort at address 100, then a fresh sweep
        begin
            int found = 0;
            int nb    = 0;
            int errs  = 0;
            int sum   = 0;
            @(negedge clk);
            start_a = 1'b1; m_ready_a = 1'b1;
            for (int k = 0; k < 300 && found == 0; k++) begin
                @(negedge clk);
                start_a = 1'b0;
                if (m_valid_a && m_addr_a == 14'd100) found = 1;
            end
            check("T5 reached addr 100", found, 1);
            #2 reset = 1'b0;
            #1;
            check("T5 abort m_valid", m_valid_a, 0);
            check("T5 abort m_data", m_data_a, 0);
            check("T5 abort m_addr", m_addr_a, 0);
            check("T5 abort m_last", m_last_a, 0);
            check("T5 abort busy", busy_a, 0);
            check("T5 abort checksum", checksum_a, 0);
            check("T5 abort raddr", raddr_a, 0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (k == 1) reset = 1'b1;
                if (done_a || busy_a) errs++;
            end
            check("T5 no done or busy after abort", errs, 0);
            start_a = 1'b1;
            for (int k = 0; k < 40 && nb < 10; k++) begin
                @(negedge clk);
                start_a = 1'b0;
                if (m_valid_a) begin
                    if (int'(m_addr_a) != nb || int'(m_data_a) != (nb & 3)) errs++;
                    sum += nb & 3;
                    nb++;
                end
            end
            @(negedge clk);
            check("T5 restart beats", nb, 10);
            check("T5 restart order errors", errs, 0);
            check("T5 restart checksum", checksum_a, 13);
            check("T5 restart checksum model", sum, 13);
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
